qbus_slave_seq: RTL
===================

QBUS_SLAVE_SEQ -- requirements
Module: qbus_slave_seq

Interface
REQ-001 SHALL have parameter NDEV, default 4: number of slave device channels, legal 1..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for RSYNC/RDIN/RDOUT, legal 2..4.
REQ-003 SHALL have parameter SETTLE, default 2: clk20 cycles DALtx is held before TRPLY on read/vector cycles, legal 0..15.
REQ-004 SHALL have parameter TMO, default 1000: clk20 cycles TRPLY may stay asserted awaiting strobe release, legal 16..65535.
REQ-005 clk20  in  1  sole clock; all state on rising edge.
REQ-006 reset_L  in  1  asynchronous, active-low reset.
REQ-007 RSYNC, RDIN, RDOUT  in  1 each  raw asynchronous QBUS receivers.
REQ-008 dev_match  in  NDEV  per-channel address match, valid while RSYNC asserted.
REQ-009 dev_vec  in  NDEV  per-channel interrupt vector request (acknowledge in progress).
REQ-010 dev_rdata  in  16*NDEV  per-channel read/vector data; channel i at [16i+15:16i].
REQ-011 dma_busy  in  1  local DMA master owns the bus; suppresses all slave responses.
REQ-012 TRPLY  out  1  reply driver.
REQ-013 DALtx, DALbe, DALst  out  1 each  Am2908 direction, bus enable, output-latch controls.
REQ-014 tdl  out  16  registered data for the transceivers.
REQ-015 dev_sel  out  NDEV  one-hot selected channel, zero when idle.
REQ-016 write_pulse  out  NDEV  one-cycle write strobe to selected channel.
REQ-017 read_pulse  out  NDEV  one-cycle read-done strobe to selected channel.
REQ-018 tmo_err  out  1  one-cycle pulse on reply timeout.

Function
REQ-019 RSYNC/RDIN/RDOUT SHALL pass through SYNC_STAGES flops; sX is last stage, rise(X) is last two stages = 01.
REQ-020 States: IDLE, RD_SETTLE, RD_REPLY, WR_REPLY, VEC_SETTLE, VEC_REPLY, WAIT_END.
REQ-021 IDLE: if dma_busy, stay; else if sRSYNC & |dev_match & sRDIN -> RD_SETTLE; else if sRSYNC & |dev_match & rise(RDOUT) -> WR_REPLY; else if ~sRSYNC & |dev_vec & sRDIN -> VEC_SETTLE.
REQ-022 Channel selection SHALL be lowest index asserted, latched into dev_sel on leaving IDLE and held until return to IDLE.
REQ-023 On leaving IDLE for a read/vector, tdl SHALL load selected dev_rdata and hold.
REQ-024 RD_SETTLE/VEC_SETTLE: DALtx=1 for SETTLE cycles (SETTLE=0: one cycle), then -> RD_REPLY/VEC_REPLY.
REQ-025 RD_REPLY/VEC_REPLY: TRPLY=DALtx=DALbe=DALst=1 until ~sRDIN, then read_pulse[sel] one cycle, -> WAIT_END.
REQ-026 Entering WR_REPLY: write_pulse[sel] one cycle; from next cycle TRPLY=1 until ~sRDOUT, then -> WAIT_END.
REQ-027 WAIT_END: all drivers 0 for one cycle, -> IDLE; prevents re-trigger on the same strobe.
REQ-028 Timeout counter SHALL run in any state asserting TRPLY; at TMO cycles drop all drivers, pulse tmo_err, -> WAIT_END, suppress read_pulse.
REQ-029 dev_match deasserting mid-cycle SHALL NOT abort; latched selection governs.
REQ-030 dma_busy rising while not IDLE SHALL NOT abort the current slave cycle.
REQ-031 Simultaneous match and vector: RSYNC decides; vector path only with ~sRSYNC.
REQ-032 DALtx, DALbe, DALst, TRPLY SHALL be registered, glitch-free outputs.

Reset
REQ-033 reset_L low SHALL immediately force IDLE, all outputs 0, tdl=0, synchronisers and timeout counter 0, including mid-cycle.
REQ-034 After reset_L rises, no response SHALL start until strobes pass the synchronisers (no false rise from reset state).

Verification
REQ-035 DATI to ch2, rdata=16'o123456, SETTLE=2: RDIN up -> DALtx after SYNC_STAGES+1, TRPLY/DALbe/DALst 2 cycles later, tdl=123456; RDIN down -> read_pulse=4'b0100, TRPLY low next cycle.
REQ-036 DATO with dev_match=4'b1010: write_pulse=4'b0010 exactly one cycle, TRPLY held until RDOUT drops.
REQ-037 Vector: RSYNC low, dev_vec=4'b1000, rdata=16'o220, RDIN up -> VEC_REPLY with tdl=220, dev_sel=4'b1000.
REQ-038 RDIN held 1200 cycles, TMO=1000: TRPLY drops at count 1000, tmo_err one pulse, no read_pulse.
REQ-039 reset_L low during RD_REPLY: all outputs 0 same cycle; dma_busy=1 with valid DATI: no TRPLY ever.

Source files
------------

// File: rtl/qbus_slave_seq.sv
// qbus_slave_seq -- QBUS slave cycle sequencer for up to eight device channels.
//
// Watches the raw QBUS strobes (RSYNC/RDIN/RDOUT) through synchronisers and
// answers DATI, DATO and interrupt-vector cycles for the lowest-numbered
// matching channel. It drives the reply line and the Am2908 transceiver
// controls. Every bus-facing output comes straight from a flop.
//
// Ports:
//   clk20, reset_L         clock, asynchronous active-low reset
//   RSYNC, RDIN, RDOUT     raw asynchronous bus receivers
//   dev_match[NDEV]        per-channel address match (valid with RSYNC)
//   dev_vec[NDEV]          per-channel interrupt vector request
//   dev_rdata[16*NDEV]     per-channel read/vector data, channel i at [16i+15:16i]
//   dma_busy               local DMA master owns the bus, no slave replies
//   TRPLY                  reply driver
//   DALtx, DALbe, DALst    transceiver direction, bus enable, output latch
//   tdl[16]                data word held for the transceivers
//   dev_sel[NDEV]          one-hot channel being served, zero when idle
//   write_pulse[NDEV]      one-cycle write strobe to the served channel
//   read_pulse[NDEV]       one-cycle read-done strobe to the served channel
//   tmo_err                one-cycle pulse when a reply times out
module qbus_slave_seq #(
  parameter int NDEV        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 2,
  parameter int TMO         = 1000
) (
  input  logic                 clk20,
  input  logic                 reset_L,
  input  logic                 RSYNC,
  input  logic                 RDIN,
  input  logic                 RDOUT,
  input  logic [NDEV-1:0]      dev_match,
  input  logic [NDEV-1:0]      dev_vec,
  input  logic [16*NDEV-1:0]   dev_rdata,
  input  logic                 dma_busy,
  output logic                 TRPLY,
  output logic                 DALtx,
  output logic                 DALbe,
  output logic                 DALst,
  output logic [15:0]          tdl,
  output logic [NDEV-1:0]      dev_sel,
  output logic [NDEV-1:0]      write_pulse,
  output logic [NDEV-1:0]      read_pulse,
  output logic                 tmo_err
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_SETTLE  = 3'd1,
    ST_RD_REPLY   = 3'd2,
    ST_WR_REPLY   = 3'd3,
    ST_VEC_SETTLE = 3'd4,
    ST_VEC_REPLY  = 3'd5,
    ST_WAIT_END   = 3'd6
  } state_t;

  // SETTLE of 0 still gives one settle cycle.
  localparam logic [3:0]  SETTLE_LAST = (SETTLE <= 1) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TMO - 1);
  localparam logic [NDEV-1:0] ONE_N   = {{(NDEV-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_rsync_sync, r_rdin_sync, r_rdout_sync;
  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_settle_cnt, w_settle_nxt;
  logic [15:0]            r_tmo_cnt, w_tmo_nxt;
  logic                   r_tmo_lock, w_tmo_lock_nxt;
  logic                   r_trply, r_daltx, r_dalbe, r_dalst, r_tmo_err;
  logic                   w_trply_nxt, w_daltx_nxt, w_dalbe_nxt, w_dalst_nxt, w_tmo_err_nxt;
  logic [15:0]            r_tdl, w_tdl_nxt;
  logic [NDEV-1:0]        r_dev_sel, w_sel_nxt;
  logic [NDEV-1:0]        r_wpulse, w_wpulse_nxt, r_rpulse, w_rpulse_nxt;
  logic                   w_srsync, w_srdin, w_srdout, w_rdout_rise;
  logic [NDEV-1:0]        w_match_oh, w_vec_oh;
  logic [15:0]            w_match_rdata, w_vec_rdata;

  assign w_srsync     = r_rsync_sync[SYNC_STAGES-1];
  assign w_srdin      = r_rdin_sync[SYNC_STAGES-1];
  assign w_srdout     = r_rdout_sync[SYNC_STAGES-1];
  // Rising RDOUT: new level has reached the next-to-last stage, last stage still low.
  assign w_rdout_rise = r_rdout_sync[SYNC_STAGES-2] & ~r_rdout_sync[SYNC_STAGES-1];

  // x & -x isolates the lowest set bit, giving lowest-index priority.
  assign w_match_oh   = dev_match & (~dev_match + ONE_N);
  assign w_vec_oh     = dev_vec & (~dev_vec + ONE_N);

  // One-hot AND-OR mux of the read data for the match and vector candidates.
  always_comb begin
    w_match_rdata = 16'h0000;
    w_vec_rdata   = 16'h0000;
    for (int i = 0; i < NDEV; i++) begin
      w_match_rdata = w_match_rdata | (dev_rdata[16*i +: 16] & {16{w_match_oh[i]}});
      w_vec_rdata   = w_vec_rdata   | (dev_rdata[16*i +: 16] & {16{w_vec_oh[i]}});
    end
  end

  // Strobe synchronisers; cleared by reset so no false rise follows reset release.
  always_ff @(posedge clk20 or negedge reset_L) begin
    if (!reset_L) begin
      r_rsync_sync <= '0;
      r_rdin_sync  <= '0;
      r_rdout_sync <= '0;
    end else begin
      r_rsync_sync <= {r_rsync_sync[SYNC_STAGES-2:0], RSYNC};
      r_rdin_sync  <= {r_rdin_sync[SYNC_STAGES-2:0], RDIN};
      r_rdout_sync <= {r_rdout_sync[SYNC_STAGES-2:0], RDOUT};
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    w_state_nxt    = r_state;
    w_settle_nxt   = r_settle_cnt;
    w_tmo_nxt      = r_tmo_cnt;
    w_sel_nxt      = r_dev_sel;
    w_tdl_nxt      = r_tdl;
    // After a timeout the master may still hold its strobe; stay locked out
    // until both data strobes are released so the same strobe is not answered twice.
    w_tmo_lock_nxt = r_tmo_lock & (w_srdin | w_srdout);
    w_trply_nxt    = 1'b0;
    w_daltx_nxt    = 1'b0;
    w_dalbe_nxt    = 1'b0;
    w_dalst_nxt    = 1'b0;
    w_tmo_err_nxt  = 1'b0;
    w_wpulse_nxt   = '0;
    w_rpulse_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        w_sel_nxt    = '0;
        w_settle_nxt = 4'd0;
        w_tmo_nxt    = 16'd0;
        if (dma_busy || r_tmo_lock) begin
          w_state_nxt = ST_IDLE;
        end else if (w_srsync && (|dev_match) && w_srdin) begin
          w_state_nxt = ST_RD_SETTLE;
          w_sel_nxt   = w_match_oh;
          w_tdl_nxt   = w_match_rdata;
          w_daltx_nxt = 1'b1;
        end else if (w_srsync && (|dev_match) && w_rdout_rise) begin
          w_state_nxt  = ST_WR_REPLY;
          w_sel_nxt    = w_match_oh;
          w_wpulse_nxt = w_match_oh;
        end else if (!w_srsync && (|dev_vec) && w_srdin) begin
          w_state_nxt = ST_VEC_SETTLE;
          w_sel_nxt   = w_vec_oh;
          w_tdl_nxt   = w_vec_rdata;
          w_daltx_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_SETTLE, ST_VEC_SETTLE: begin
        w_daltx_nxt = 1'b1;
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = (r_state == ST_RD_SETTLE) ? ST_RD_REPLY : ST_VEC_REPLY;
          w_trply_nxt = 1'b1;
          w_dalbe_nxt = 1'b1;
          w_dalst_nxt = 1'b1;
        end else begin
          w_settle_nxt = r_settle_cnt + 4'd1;
        end
      end
      ST_RD_REPLY, ST_VEC_REPLY: begin
        if (!w_srdin) begin
          w_state_nxt  = ST_WAIT_END;
          w_rpulse_nxt = r_dev_sel;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt    = ST_WAIT_END;
          w_tmo_err_nxt  = 1'b1;
          w_tmo_lock_nxt = 1'b1;
        end else begin
          w_tmo_nxt   = r_tmo_cnt + 16'd1;
          w_trply_nxt = 1'b1;
          w_daltx_nxt = 1'b1;
          w_dalbe_nxt = 1'b1;
          w_dalst_nxt = 1'b1;
        end
      end
      ST_WR_REPLY: begin
        // First cycle carries only write_pulse; reply starts on the next one.
        if (!r_trply) begin
          w_trply_nxt = 1'b1;
        end else if (!w_srdout) begin
          w_state_nxt = ST_WAIT_END;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt    = ST_WAIT_END;
          w_tmo_err_nxt  = 1'b1;
          w_tmo_lock_nxt = 1'b1;
        end else begin
          w_tmo_nxt   = r_tmo_cnt + 16'd1;
          w_trply_nxt = 1'b1;
        end
      end
      ST_WAIT_END: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk20 or negedge reset_L) begin
    if (!reset_L) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= 4'd0;
      r_tmo_cnt    <= 16'd0;
      r_tmo_lock   <= 1'b0;
      r_trply      <= 1'b0;
      r_daltx      <= 1'b0;
      r_dalbe      <= 1'b0;
      r_dalst      <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_tdl        <= 16'h0000;
      r_dev_sel    <= '0;
      r_wpulse     <= '0;
      r_rpulse     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_tmo_lock   <= w_tmo_lock_nxt;
      r_trply      <= w_trply_nxt;
      r_daltx      <= w_daltx_nxt;
      r_dalbe      <= w_dalbe_nxt;
      r_dalst      <= w_dalst_nxt;
      r_tmo_err    <= w_tmo_err_nxt;
      r_tdl        <= w_tdl_nxt;
      r_dev_sel    <= w_sel_nxt;
      r_wpulse     <= w_wpulse_nxt;
      r_rpulse     <= w_rpulse_nxt;
    end
  end

  assign TRPLY       = r_trply;
  assign DALtx       = r_daltx;
  assign DALbe       = r_dalbe;
  assign DALst       = r_dalst;
  assign tmo_err     = r_tmo_err;
  assign tdl         = r_tdl;
  assign dev_sel     = r_dev_sel;
  assign write_pulse = r_wpulse;
  assign read_pulse  = r_rpulse;

endmodule
